// File: rtl/mem_stage_core_if.sv
// MEM-stage bus: EX/MEM control and operands in, load data and branch select out.
interface mem_stage_core_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              branch;
    logic              zero;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] data_out;
    logic              pc_src;

    // Pipeline side driving the stage.
    modport master (
        output branch,
        output zero,
        output mem_write,
        output address,
        output write_data,
        input  data_out,
        input  pc_src
    );

    // The stage itself.
    modport slave (
        input  branch,
        input  zero,
        input  mem_write,
        input  address,
        input  write_data,
        output data_out,
        output pc_src
    );
endinterface

// File: rtl/mem_stage_core.sv
// MEM stage: resettable register-file data memory with combinational read,
// plus the branch-taken decision feeding the IF-stage PC mux.
module mem_stage_core #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic             no_clk,
    input  logic             rst_n,
    mem_stage_core_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next memory image: full-word store to the addressed word when enabled.
    always_comb begin
        mem_d = mem_q;
        if (bus.mem_write) begin
            mem_d[bus.address] = bus.write_data;
        end
    end

    // Storage flops; async reset clears every word and blocks writes.
    always_ff @(posedge no_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Zero-latency read with no write bypass; old data visible until the edge.
    assign bus.data_out = mem_q[bus.address];

    // Branch taken only for a beq whose operands compared equal.
    assign bus.pc_src = bus.branch & bus.zero;
endmodule

// File: tb/tb_mem_stage_core.sv
// Bench for mem_stage_core: directed scenarios plus randomized traffic
// checked by a queue-based scoreboard against an array model of memory.
module tb_mem_stage_core;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned N_RAND = 400;

    typedef struct {
        logic [DATA_W-1:0] dout;
        logic              pc;
    } exp_t;

    logic no_clk;
    logic rst_n;
    logic clk_en;

    mem_stage_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_stage_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .no_clk (no_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    logic [DATA_W-1:0] model [DEPTH];
    exp_t              exp_q [$];
    int                checks   = 0;
    int                failures = 0;
    int                pushed   = 0;
    int                popped   = 0;

    // Gated clock: holds its level while clk_en is low.
    initial no_clk = 1'b0;
    always #5 if (clk_en) no_clk = ~no_clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // Monitor: after each rising edge, compare outputs with the oldest expectation.
    always @(posedge no_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            check("rand_data_out", bus.data_out, e.dout);
            check("rand_pc_src", 32'(bus.pc_src), 32'(e.pc));
        end
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic              we, br, zr;
        exp_t              e;

        // Reset with a pending write and branch asserted.
        clk_en         = 1'b1;
        rst_n          = 1'b0;
        bus.mem_write  = 1'b1;
        bus.address    = '0;
        bus.write_data = 32'd10;
        bus.branch     = 1'b1;
        bus.zero       = 1'b1;
        model_clear();
        #1;
        check("reset_data_out_early", bus.data_out, 32'h0);
        @(posedge no_clk);
        @(negedge no_clk);
        check("reset_write_ignored", bus.data_out, 32'h0);
        check("reset_pc_src_11", 32'(bus.pc_src), 32'd1);
        bus.zero = 1'b0;
        #1;
        check("reset_pc_src_10", 32'(bus.pc_src), 32'd0);

        // Store then load back; value persists once writes stop.
        bus.write_data = 32'd4;
        rst_n          = 1'b1;
        @(posedge no_clk);
        #1;
        check("store_load_0", bus.data_out, 32'd4);
        @(negedge no_clk);
        bus.mem_write  = 1'b0;
        bus.write_data = '0;
        repeat (2) @(posedge no_clk);
        #1;
        check("store_hold_0", bus.data_out, 32'd4);

        // Async reset pulse between edges clears memory without a clock.
        @(negedge no_clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_clear", bus.data_out, 32'h0);
        #1;
        rst_n = 1'b1;
        model_clear();

        // Clock held low: write request must not land.
        @(negedge no_clk);
        clk_en         = 1'b0;
        bus.mem_write  = 1'b1;
        bus.address    = ADDR_W'(5);
        bus.write_data = 32'd10;
        #100;
        check("no_edge_no_write", bus.data_out, 32'h0);

        // Branch decode with no edge.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] bz;
            bz = 2'(i);
            bus.branch = bz[1];
            bus.zero   = bz[0];
            #1;
            check($sformatf("pc_src_bz%0d%0d", bz[1], bz[0]),
                  32'(bus.pc_src), 32'(bz[1] & bz[0]));
        end
        bus.mem_write = 1'b0;
        #2;
        clk_en = 1'b1;
        @(posedge no_clk);
        #1;
        check("no_edge_after_resume", bus.data_out, 32'h0);

        // Extreme data at extreme addresses.
        @(negedge no_clk);
        bus.mem_write  = 1'b1;
        bus.address    = ADDR_W'(DEPTH - 1);
        bus.write_data = 32'hFFFF_FFFF;
        model[DEPTH-1] = 32'hFFFF_FFFF;
        @(negedge no_clk);
        bus.address    = '0;
        bus.write_data = 32'hA5A5_5A5A;
        model[0]       = 32'hA5A5_5A5A;
        @(negedge no_clk);
        bus.mem_write  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int unsigned addrs [6];
            addrs = '{DEPTH - 1, 0, 1, 5, 512, DEPTH - 2};
            bus.address = ADDR_W'(addrs[i]);
            #1;
            check($sformatf("extreme_rd_%0d", addrs[i]), bus.data_out, model[addrs[i]]);
        end

        // Randomized traffic; addresses biased to a small window for reuse.
        for (int n = 0; n < int'(N_RAND); n++) begin
            @(negedge no_clk);
            if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, DEPTH - 1));
            else if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? ADDR_W'(DEPTH - 1) : '0;
            else a = ADDR_W'($urandom_range(0, 15));
            wd = DATA_W'($urandom());
            we = ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 1) == 1);
            zr = ($urandom_range(0, 1) == 1);
            bus.address    = a;
            bus.write_data = wd;
            bus.mem_write  = we;
            bus.branch     = br;
            bus.zero       = zr;
            #1;
            check("rand_pre_edge_old", bus.data_out, model[a]);
            if (we) model[a] = wd;
            e.dout = model[a];
            e.pc   = br & zr;
            exp_q.push_back(e);
            pushed++;
        end

        @(negedge no_clk);
        bus.mem_write = 1'b0;
        @(posedge no_clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("scoreboard_count", 32'(popped), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
